// File: rtl/wishbone_bus_if_pkg.sv
// Shared types for the core-to-Wishbone bridge: state encoding and ctrl stall width.
package wishbone_bus_if_pkg;

  localparam int STALL_W = 6;

  typedef enum logic [1:0] {
    WB_IDLE           = 2'b00,
    WB_BUSY           = 2'b01,
    WB_WAIT_FOR_STALL = 2'b11
  } wb_state_e;

endpackage

// File: rtl/wishbone_bus_if.sv
// Bridges one core memory port onto a Wishbone B4 classic master, one cycle at a time,
// requesting a pipeline stall until the slave acknowledges.
module wishbone_bus_if
  import wishbone_bus_if_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SW = DW / 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall_i,
  input  logic               flush_i,
  input  logic               cpu_ce_i,
  input  logic               cpu_we_i,
  input  logic [AW-1:0]      cpu_addr_i,
  input  logic [SW-1:0]      cpu_sel_i,
  input  logic [DW-1:0]      cpu_data_i,
  output logic [DW-1:0]      cpu_data_o,
  output logic               stallreq_o,
  input  logic               wb_ack_i,
  input  logic [DW-1:0]      wb_data_i,
  output logic [AW-1:0]      wb_addr_o,
  output logic [DW-1:0]      wb_data_o,
  output logic [SW-1:0]      wb_sel_o,
  output logic               wb_we_o,
  output logic               wb_stb_o,
  output logic               wb_cyc_o
);

  wb_state_e     state_q;
  logic [AW-1:0] wb_addr_q;
  logic [DW-1:0] wb_data_q;
  logic [SW-1:0] wb_sel_q;
  logic          wb_we_q;
  logic          wb_stb_q;
  logic          wb_cyc_q;
  logic [DW-1:0] rd_buf_q;
  // Direction of the current/last access; wb_we_q is already cleared once we reach WAIT_FOR_STALL.
  logic          req_we_q;

  // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WB_IDLE;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      wb_sel_q  <= '0;
      wb_we_q   <= 1'b0;
      wb_stb_q  <= 1'b0;
      wb_cyc_q  <= 1'b0;
      rd_buf_q  <= '0;
      req_we_q  <= 1'b0;
    end else begin
      case (state_q)
        WB_IDLE: begin
          if (cpu_ce_i && !flush_i) begin
            wb_addr_q <= cpu_addr_i;
            wb_data_q <= cpu_data_i;
            wb_sel_q  <= cpu_sel_i;
            wb_we_q   <= cpu_we_i;
            wb_stb_q  <= 1'b1;
            wb_cyc_q  <= 1'b1;
            req_we_q  <= cpu_we_i;
            state_q   <= WB_BUSY;
          end
        end
        WB_BUSY: begin
          if (flush_i) begin
            wb_we_q  <= 1'b0;
            wb_stb_q <= 1'b0;
            wb_cyc_q <= 1'b0;
            state_q  <= WB_IDLE;
          end else if (wb_ack_i) begin
            wb_we_q  <= 1'b0;
            wb_stb_q <= 1'b0;
            wb_cyc_q <= 1'b0;
            rd_buf_q <= wb_data_i;
            state_q  <= (stall_i != '0) ? WB_WAIT_FOR_STALL : WB_IDLE;
          end
        end
        WB_WAIT_FOR_STALL: begin
          // Hold the returned data until ctrl releases the pipeline; never re-issue from here.
          if (stall_i == '0 || flush_i) begin
            state_q <= WB_IDLE;
          end
        end
        default: begin
          wb_we_q  <= 1'b0;
          wb_stb_q <= 1'b0;
          wb_cyc_q <= 1'b0;
          state_q  <= WB_IDLE;
        end
      endcase
    end
  end

  // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
  always_comb begin
    stallreq_o = 1'b0;
    cpu_data_o = '0;
    if (!rst) begin
      case (state_q)
        WB_IDLE: stallreq_o = cpu_ce_i && !flush_i;
        WB_BUSY: begin
          if (!flush_i) begin
            if (wb_ack_i) cpu_data_o = req_we_q ? '0 : wb_data_i;
            else          stallreq_o = 1'b1;
          end
        end
        WB_WAIT_FOR_STALL: cpu_data_o = req_we_q ? '0 : rd_buf_q;
        default: ;
      endcase
    end
  end

  assign wb_addr_o = wb_addr_q;
  assign wb_data_o = wb_data_q;
  assign wb_sel_o  = wb_sel_q;
  assign wb_we_o   = wb_we_q;
  assign wb_stb_o  = wb_stb_q;
  assign wb_cyc_o  = wb_cyc_q;

endmodule
